// File: rtl/seg_scan_driver_pkg.sv
// Shared constants and helpers for the segment scan path (pattern encoders upstream use the same defaults).
// Optional feature macro: SEG_DIMMING_EN (adds the brightness input).
package seg_scan_driver_pkg;

  localparam int DIGITS_DEF       = 6;
  localparam int SEG_W_DEF        = 7;
  localparam int TICK_DIV_DEF     = 50000;
  localparam int BLANK_CYCLES_DEF = 2;

  typedef struct packed {
    logic wrap;  // last cycle of the last digit slot
    logic lit;   // current cnt lies inside the lit window
  } tick_flags_t;

  // Exclusive end of the lit window for a given 3-bit brightness code.
  function automatic logic [31:0] lit_end(input logic [31:0] tick_div,
                                          input logic [31:0] blank,
                                          input logic [2:0]  br);
    return blank + (((32'(br) + 32'd1) * (tick_div - blank)) >> 3);
  endfunction

endpackage

// File: rtl/seg_scan_if.sv
// Pattern bus in, shared seg/an pins and frame pulse out.
// Optional feature macro: SEG_DIMMING_EN (adds brightness).
interface seg_scan_if #(
  parameter int DIGITS = 6,
  parameter int SEG_W  = 7
);
  logic [DIGITS*SEG_W-1:0] display;
  logic [SEG_W-1:0]        seg;
  logic [DIGITS-1:0]       an;
  logic                    frame_start;
`ifdef SEG_DIMMING_EN
  logic [2:0]              brightness;

  modport master (output display, brightness, input seg, an, frame_start);
  modport slave  (input display, brightness, output seg, an, frame_start);
`else
  modport master (output display, input seg, an, frame_start);
  modport slave  (input display, output seg, an, frame_start);
`endif
endinterface

// File: rtl/seg_scan_tick_gen.sv
// Slot timer: cycle counter, digit index, frame wrap and lit-window decode.
// Optional feature macro: SEG_DIMMING_EN (shortens the lit window by brightness).
module scan_tick_gen
  import seg_scan_driver_pkg::*;
#(
  parameter  int DIGITS       = DIGITS_DEF,
  parameter  int TICK_DIV     = TICK_DIV_DEF,
  parameter  int BLANK_CYCLES = BLANK_CYCLES_DEF,
  localparam int CW           = $clog2(TICK_DIV),
  localparam int IW           = (DIGITS > 1) ? $clog2(DIGITS) : 1
) (
  input  logic          clk,
  input  logic          reset,
`ifdef SEG_DIMMING_EN
  input  logic [2:0]    brightness_i,
`endif
  output logic [IW-1:0] idx_o,
  output tick_flags_t   flags_o
);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [IW-1:0] idx_q, idx_d;
  logic          slot_end;
  logic [31:0]   cnt32;

  assign slot_end = (cnt_q == CW'(TICK_DIV - 1));
  assign cnt32    = 32'(cnt_q);

  always_comb begin
    cnt_d = slot_end ? '0 : cnt_q + 1'b1;
    idx_d = idx_q;
    if (slot_end)
      idx_d = (idx_q == IW'(DIGITS - 1)) ? '0 : idx_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
      idx_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      idx_q <= idx_d;
    end
  end

  assign idx_o        = idx_q;
  assign flags_o.wrap = slot_end && (idx_q == IW'(DIGITS - 1));
`ifdef SEG_DIMMING_EN
  // Brightness is taken live every cycle; only the display frame is snapshotted.
  assign flags_o.lit  = (cnt32 >= 32'(BLANK_CYCLES)) &&
                        (cnt32 <  lit_end(32'(TICK_DIV), 32'(BLANK_CYCLES), brightness_i));
`else
  assign flags_o.lit  = (cnt32 >= 32'(BLANK_CYCLES));
`endif

endmodule

// File: rtl/seg_scan_driver.sv
// Time-multiplexes a DIGITS x SEG_W pattern bus onto shared seg/an pins with per-frame snapshot.
// Optional feature macro: SEG_DIMMING_EN (brightness-controlled on-time).
module seg_scan_driver
  import seg_scan_driver_pkg::*;
#(
  parameter int DIGITS       = DIGITS_DEF,
  parameter int SEG_W        = SEG_W_DEF,
  parameter int TICK_DIV     = TICK_DIV_DEF,
  parameter int BLANK_CYCLES = BLANK_CYCLES_DEF,
  parameter int ACTIVE_LOW   = 1
) (
  input logic        clk,
  input logic        reset,
  seg_scan_if.slave  bus
);

  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  // Off levels double as XOR masks that apply pin polarity.
  localparam logic [SEG_W-1:0]  SEG_OFF = (ACTIVE_LOW != 0) ? '1 : '0;
  localparam logic [DIGITS-1:0] AN_OFF  = (ACTIVE_LOW != 0) ? '1 : '0;

  logic [IW-1:0]                  idx;
  tick_flags_t                    flags;
  logic [DIGITS-1:0][SEG_W-1:0]   frame_q, frame_d;
  logic [SEG_W-1:0]               seg_q, seg_d;
  logic [DIGITS-1:0]              an_q, an_d;
  logic                           fs_q, fs_d;

  scan_tick_gen #(
    .DIGITS       (DIGITS),
    .TICK_DIV     (TICK_DIV),
    .BLANK_CYCLES (BLANK_CYCLES)
  ) u_tick (
    .clk          (clk),
    .reset        (reset),
`ifdef SEG_DIMMING_EN
    .brightness_i (bus.brightness),
`endif
    .idx_o        (idx),
    .flags_o      (flags)
  );

  always_comb begin
    frame_d = flags.wrap ? bus.display : frame_q;
    fs_d    = flags.wrap;
    seg_d   = SEG_OFF;
    an_d    = AN_OFF;
    if (flags.lit) begin
      seg_d = frame_q[idx] ^ SEG_OFF;
      an_d  = (DIGITS'(1) << idx) ^ AN_OFF;
    end
  end

  // Reset keeps reloading the frame so the first post-reset slot shows current data.
  always_ff @(posedge clk) begin
    if (reset) begin
      frame_q <= bus.display;
      fs_q    <= 1'b0;
      seg_q   <= SEG_OFF;
      an_q    <= AN_OFF;
    end else begin
      frame_q <= frame_d;
      fs_q    <= fs_d;
      seg_q   <= seg_d;
      an_q    <= an_d;
    end
  end

  assign bus.seg         = seg_q;
  assign bus.an          = an_q;
  assign bus.frame_start = fs_q;

endmodule
